// File: rtl/dispatch_sched_pkg.sv
// Shared constants for the dispatch admission controller: opcode map, op classes, FSM codes.
// The optional stall counters in dispatch_sched are built only when DISPATCH_PERF_EN is defined.
package dispatch_sched_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_LB    = 6'd11;
    localparam logic [OP_W-1:0] OP_LH    = 6'd12;
    localparam logic [OP_W-1:0] OP_LW    = 6'd13;
    localparam logic [OP_W-1:0] OP_SB    = 6'd14;
    localparam logic [OP_W-1:0] OP_SH    = 6'd15;
    localparam logic [OP_W-1:0] OP_SW    = 6'd16;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd30;

    typedef enum logic {
        CLS_RS = 1'b0,
        CLS_LS = 1'b1
    } op_class_t;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Simultaneous allocate and release cancel out; a release at zero is ignored.
    function automatic int unsigned nextCount(input int unsigned cnt, input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + 1;
        if (dec && !inc && cnt != 0)
            return cnt - 1;
        return cnt;
    endfunction

endpackage

// File: rtl/dispatch_sched_op_class.sv
// Combinational opcode classifier: loads and stores go to the SLB, everything else to the RS.
module dp_op_class
    import dispatch_sched_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output logic            o_isLs
);

    op_class_t w_cls;

    always_comb begin
        w_cls = CLS_RS;
        if ((i_op >= OP_LB && i_op <= OP_LW) || (i_op >= OP_SB && i_op <= OP_SW))
            w_cls = CLS_LS;
    end

    assign o_isLs = (w_cls == CLS_LS);

endmodule

// File: rtl/dispatch_sched.sv
// Dispatch admission controller: ROB/RS/SLB credit tracking, ROB nick allocation, flush handling.
// Define DISPATCH_PERF_EN to add the saturating stall counters and their oPERF_* ports.
module dispatch_sched
    import dispatch_sched_pkg::*;
#(
    parameter int NICK_W    = 4,
    parameter int RS_DEPTH  = 16,
    parameter int SLB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iDEC_en,
    input  logic [OP_W-1:0]   iDEC_op,
    output logic              oDP_rdy,
    output logic              oDP_fire,
    output logic              oDP_to_rs,
    output logic              oDP_to_slb,
    output logic              oROB_nick_en,
    output logic [NICK_W-1:0] oROB_nick,
`ifdef DISPATCH_PERF_EN
    output logic [31:0]       oPERF_stall_rob,
    output logic [31:0]       oPERF_stall_rs,
    output logic [31:0]       oPERF_stall_slb,
`endif
    input  logic              iRS_free,
    input  logic              iSLB_free,
    input  logic              iROB_commit,
    input  logic              iROB_clr
);

    localparam int RS_CW  = $clog2(RS_DEPTH + 1);
    localparam int SLB_CW = $clog2(SLB_DEPTH + 1);

    localparam logic [NICK_W-1:0] ROB_FULL  = '1;
    localparam logic [NICK_W-1:0] NICK_ONE  = NICK_W'(1);
    localparam logic [RS_CW-1:0]  RS_FULL   = RS_CW'(RS_DEPTH);
    localparam logic [SLB_CW-1:0] SLB_FULL  = SLB_CW'(SLB_DEPTH);

    logic [0:0]        r_state;
    logic [NICK_W-1:0] r_robCnt;
    logic [RS_CW-1:0]  r_rsCnt;
    logic [SLB_CW-1:0] r_slbCnt;
    logic [NICK_W-1:0] r_tail;

    logic w_isLs;
    logic w_unitOk;
    logic w_fire;

    dp_op_class u_opClass (
        .i_op   (iDEC_op),
        .o_isLs (w_isLs)
    );

    // Admission looks only at registered counts, so a release never grants in its own cycle.
    assign w_unitOk     = w_isLs ? (r_slbCnt < SLB_FULL) : (r_rsCnt < RS_FULL);
    assign oDP_rdy      = (r_state == ST_RUN) & ~iROB_clr & (r_robCnt < ROB_FULL) & w_unitOk;
    assign w_fire       = iDEC_en & oDP_rdy & rdy;
    assign oDP_fire     = w_fire;
    assign oDP_to_rs    = w_fire & ~w_isLs;
    assign oDP_to_slb   = w_fire & w_isLs;
    assign oROB_nick_en = w_fire;
    assign oROB_nick    = r_tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_robCnt <= '0;
            r_rsCnt  <= '0;
            r_slbCnt <= '0;
            r_tail   <= NICK_ONE;
        end else if (rdy) begin
            if (r_state == ST_FLUSH) begin
                r_state <= ST_RUN;
            end else if (iROB_clr) begin
                r_state  <= ST_FLUSH;
                r_robCnt <= '0;
                r_rsCnt  <= '0;
                r_slbCnt <= '0;
                r_tail   <= NICK_ONE;
            end else begin
                r_robCnt <= NICK_W'(nextCount(32'(r_robCnt), w_fire, iROB_commit));
                r_rsCnt  <= RS_CW'(nextCount(32'(r_rsCnt), w_fire & ~w_isLs, iRS_free));
                r_slbCnt <= SLB_CW'(nextCount(32'(r_slbCnt), w_fire & w_isLs, iSLB_free));
                // Nick 0 means "no dependency", so the tail skips it on wrap.
                if (w_fire)
                    r_tail <= (r_tail == ROB_FULL) ? NICK_ONE : r_tail + NICK_ONE;
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic w_offer;

    assign w_offer = iDEC_en & rdy;

    // Stall counters survive flushes; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oPERF_stall_rob <= '0;
            oPERF_stall_rs  <= '0;
            oPERF_stall_slb <= '0;
        end else begin
            if (w_offer && r_robCnt == ROB_FULL && oPERF_stall_rob != '1)
                oPERF_stall_rob <= oPERF_stall_rob + 32'd1;
            if (w_offer && !w_isLs && r_rsCnt == RS_FULL && oPERF_stall_rs != '1)
                oPERF_stall_rs <= oPERF_stall_rs + 32'd1;
            if (w_offer && w_isLs && r_slbCnt == SLB_FULL && oPERF_stall_slb != '1)
                oPERF_stall_slb <= oPERF_stall_slb + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_sched.sv
// Self-checking bench for dispatch_sched: per-cycle model comparison plus directed literal checks.
// The stall-counter scenario runs only when DISPATCH_PERF_EN is defined.
module tb_dispatch_sched;
    import dispatch_sched_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic            iDEC_en;
    logic [OP_W-1:0] iDEC_op;
    logic            oDP_rdy;
    logic            oDP_fire;
    logic            oDP_to_rs;
    logic            oDP_to_slb;
    logic            oROB_nick_en;
    logic [3:0]      oROB_nick;
    logic            iRS_free;
    logic            iSLB_free;
    logic            iROB_commit;
    logic            iROB_clr;
`ifdef DISPATCH_PERF_EN
    logic [31:0]     oPERF_stall_rob;
    logic [31:0]     oPERF_stall_rs;
    logic [31:0]     oPERF_stall_slb;
`endif

    int checks = 0;
    int passes = 0;

    int mRob, mRs, mSlb, mTail;
    bit mFlush;

    dispatch_sched #(.NICK_W(4), .RS_DEPTH(16), .SLB_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .iDEC_en      (iDEC_en),
        .iDEC_op      (iDEC_op),
        .oDP_rdy      (oDP_rdy),
        .oDP_fire     (oDP_fire),
        .oDP_to_rs    (oDP_to_rs),
        .oDP_to_slb   (oDP_to_slb),
        .oROB_nick_en (oROB_nick_en),
        .oROB_nick    (oROB_nick),
`ifdef DISPATCH_PERF_EN
        .oPERF_stall_rob (oPERF_stall_rob),
        .oPERF_stall_rs  (oPERF_stall_rs),
        .oPERF_stall_slb (oPERF_stall_slb),
`endif
        .iRS_free     (iRS_free),
        .iSLB_free    (iSLB_free),
        .iROB_commit  (iROB_commit),
        .iROB_clr     (iROB_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive one cycle's inputs just after the rising edge and return at the following falling edge.
    task automatic applyStimulus(input logic en, input logic [OP_W-1:0] op, input logic rsF,
                                 input logic slbF, input logic commit, input logic clr, input logic rdyV);
        @(posedge clk);
        #1;
        iDEC_en     = en;
        iDEC_op     = op;
        iRS_free    = rsF;
        iSLB_free   = slbF;
        iROB_commit = commit;
        iROB_clr    = clr;
        rdy         = rdyV;
        @(negedge clk);
    endtask

    function automatic bit isLsRef(input logic [OP_W-1:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW ||
               op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic int creditStep(input int cnt, input bit inc, input bit dec);
        int n;
        n = cnt + int'(inc) - int'(dec);
        return (n < 0) ? 0 : n;
    endfunction

    // Reference model: checks outputs every cycle, then advances to the state after the next edge.
    always @(negedge clk) begin : cmpProc
        bit ls, expRdy, expFire;
        int expVec, actVec;
        if (rst) begin
            mRob = 0; mRs = 0; mSlb = 0; mTail = 1; mFlush = 0;
        end else begin
            ls      = isLsRef(iDEC_op);
            expRdy  = !mFlush && !iROB_clr && mRob < 15 && (ls ? mSlb < 16 : mRs < 16);
            expFire = expRdy && iDEC_en && rdy;
            expVec  = (int'(expRdy) << 8) | (int'(expFire) << 7) | (int'(expFire && !ls) << 6) |
                      (int'(expFire && ls) << 5) | (int'(expFire) << 4) | mTail;
            actVec  = (int'(oDP_rdy) << 8) | (int'(oDP_fire) << 7) | (int'(oDP_to_rs) << 6) |
                      (int'(oDP_to_slb) << 5) | (int'(oROB_nick_en) << 4) | int'(oROB_nick);
            checkOutput("cycle_outputs", actVec, expVec);
            if (rdy) begin
                if (mFlush) begin
                    mFlush = 0;
                end else if (iROB_clr) begin
                    mRob = 0; mRs = 0; mSlb = 0; mTail = 1; mFlush = 1;
                end else begin
                    mRob = creditStep(mRob, expFire, iROB_commit);
                    mRs  = creditStep(mRs, expFire && !ls, iRS_free);
                    mSlb = creditStep(mSlb, expFire && ls, iSLB_free);
                    if (expFire)
                        mTail = (mTail == 15) ? 1 : mTail + 1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; iDEC_en = 1'b0; iDEC_op = OP_ADDI;
        iRS_free = 1'b0; iSLB_free = 1'b0; iROB_commit = 1'b0; iROB_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("reset_rdy", oDP_rdy, 1);
        checkOutput("reset_nick", oROB_nick, 1);
        checkOutput("reset_fire", oDP_fire, 0);

        // Fill the ROB with ADDIs, then confirm it refuses a 16th.
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
            checkOutput("t1_nick", oROB_nick, i);
        end
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("t1_rob_full", oDP_rdy, 0);

        applyStimulus(0, OP_ADDI, 0, 0, 1, 0, 1);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("t2_rdy", oDP_rdy, 1);
        checkOutput("t2_wrap_nick", oROB_nick, 1);

        // RS now holds 16; a release in the same cycle must not grant.
        applyStimulus(0, OP_ADDI, 0, 0, 1, 0, 1);
        applyStimulus(1, OP_ADD, 1, 0, 0, 0, 1);
        checkOutput("t4_block", oDP_fire, 0);
        applyStimulus(1, OP_ADD, 0, 0, 0, 0, 1);
        checkOutput("t4_after_free", oDP_fire, 1);
        checkOutput("t4_nick", oROB_nick, 2);

        applyStimulus(0, OP_ADDI, 0, 0, 0, 1, 1);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("flush_nick", oROB_nick, 1);

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, OP_LW, 0, 0, 1, 0, 1);
            checkOutput("t3_lw_fire", oDP_to_slb, 1);
        end
        applyStimulus(1, OP_LW, 0, 0, 0, 0, 1);
        checkOutput("t3_slb_full", oDP_rdy, 0);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("t3_addi_to_rs", oDP_to_rs, 1);
        checkOutput("t3_addi_nick", oROB_nick, 2);

        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 0);
        checkOutput("rdy0_nofire", oDP_fire, 0);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("rdy0_frozen_nick", oROB_nick, 3);

        // A clear held across a frozen cycle takes effect once rdy returns.
        applyStimulus(0, OP_ADDI, 0, 0, 0, 1, 0);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 1, 1);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);

        for (int i = 1; i <= 7; i++)
            applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 1, 1);
        checkOutput("t5_clr_rdy", oDP_rdy, 0);
        checkOutput("t5_clr_nofire", oDP_fire, 0);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("t5_flush_rdy", oDP_rdy, 0);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("t5_run_rdy", oDP_rdy, 1);
        checkOutput("t5_nick", oROB_nick, 1);

        applyStimulus(1, OP_SW, 0, 0, 0, 0, 1);
        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_rst_nick", oROB_nick, 1);
        checkOutput("async_rst_rdy", oDP_rdy, 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Releases on empty counters must saturate at zero.
        applyStimulus(0, OP_ADDI, 1, 1, 1, 0, 1);
        for (int i = 1; i <= 15; i++)
            applyStimulus(1, OP_SB, 0, 0, 0, 0, 1);
        applyStimulus(1, OP_ADDI, 0, 0, 0, 0, 1);
        checkOutput("sat_rob_full", oDP_rdy, 0);

`ifdef DISPATCH_PERF_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 16; i++)
            applyStimulus(1, OP_LW, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, OP_LW, 0, 0, 0, 0, 1);
            applyStimulus(1, OP_LW, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, OP_LW, 0, 0, 0, 0, 1);
        checkOutput("t6_stall_slb", oPERF_stall_slb, 5);
        checkOutput("t6_stall_rob", oPERF_stall_rob, 0);
        checkOutput("t6_stall_rs", oPERF_stall_rs, 0);
`endif

        applyStimulus(0, OP_ADDI, 0, 0, 0, 0, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
